// File: rtl/param_seq_detect_pkg.sv
// Shared types and reset-time defaults for the programmable serial sequence detector.
package param_seq_detect_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HUNT  = 2'd1,
        S_MATCH = 2'd2
    } state_e;

    localparam int          PKG_MAX_LEN     = 8;
    localparam int          PKG_LEN_W       = 4;
    localparam int          PKG_CNT_W       = 8;
    localparam logic [7:0]  PKG_DEF_PATTERN = 8'b0000_1001;
    localparam int          PKG_DEF_LEN     = 4;

endpackage

// File: rtl/param_seq_detect_if.sv
// Serial-bit, configuration and status bundle between a bit source/controller and the detector.
interface param_seq_detect_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               en;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  z, match_cnt, cfg_err
    );

    modport slave (
        input  en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output z, match_cnt, cfg_err
    );
endinterface

// File: rtl/param_seq_detect_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment restarts the count at one.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    // Count register: clear has priority, increment stops at all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= {CNT_W{1'b0}};
        end else if (clr) begin
            q <= inc ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + CNT_W'(1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/param_seq_detect.sv
// Runtime-programmable Moore sequence detector: compares the last len sampled bits
// against a loaded pattern, with selectable overlap and a saturating match count.
module param_seq_detect
    import param_seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = PKG_MAX_LEN,
    parameter int                 LEN_W       = PKG_LEN_W,
    parameter int                 CNT_W       = PKG_CNT_W,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(PKG_DEF_PATTERN),
    parameter int                 DEF_LEN     = PKG_DEF_LEN
) (
    input  logic               clk,
    input  logic               reset,
    param_seq_detect_if.slave  bus
);

    state_e             state_r, state_next_s;
    logic [MAX_LEN-2:0] hist_r, hist_next_s;
    logic [LEN_W-1:0]   fill_r, fill_next_s, fill_inc_s;
    logic [MAX_LEN-1:0] pattern_r, mask_s, hist_shift_s;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic               z_r;
    logic               cfg_err_r;
    logic               cfg_ok_s;
    logic               sample_s;
    logic               match_s;

    // Masked compare of the would-be history plus next-state selection.
    always_comb begin
        hist_shift_s = {hist_r, bus.x};
        fill_inc_s   = (fill_r >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : (fill_r + LEN_W'(1));
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_r));
        end
        cfg_ok_s = bus.cfg_load && (bus.cfg_len != {LEN_W{1'b0}}) && (bus.cfg_len <= LEN_W'(MAX_LEN));
        sample_s = bus.en && !bus.cfg_load;
        match_s  = sample_s && (fill_inc_s >= len_r)
                   && (((hist_shift_s ^ pattern_r) & mask_s) == {MAX_LEN{1'b0}});

        hist_next_s  = hist_r;
        fill_next_s  = fill_r;
        state_next_s = state_r;
        if (cfg_ok_s) begin
            hist_next_s  = {(MAX_LEN-1){1'b0}};
            fill_next_s  = {LEN_W{1'b0}};
            state_next_s = S_IDLE;
        end else if (sample_s) begin
            hist_next_s = hist_shift_s[MAX_LEN-2:0];
            // Non-overlapping mode demands a full fresh window after each match.
            fill_next_s = (match_s && !overlap_r) ? {LEN_W{1'b0}} : fill_inc_s;
            if (match_s) begin
                state_next_s = S_MATCH;
            end else if (fill_next_s != {LEN_W{1'b0}}) begin
                state_next_s = S_HUNT;
            end else begin
                state_next_s = S_IDLE;
            end
        end else begin
            case (state_r)
                S_MATCH: state_next_s = S_HUNT;
                S_IDLE:  state_next_s = S_IDLE;
                S_HUNT:  state_next_s = S_HUNT;
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // State, history, configuration and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            hist_r    <= {(MAX_LEN-1){1'b0}};
            fill_r    <= {LEN_W{1'b0}};
            pattern_r <= DEF_PATTERN;
            len_r     <= LEN_W'(DEF_LEN);
            overlap_r <= 1'b1;
            z_r       <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            hist_r    <= hist_next_s;
            fill_r    <= fill_next_s;
            z_r       <= (state_next_s == S_MATCH);
            cfg_err_r <= bus.cfg_load && !cfg_ok_s;
            if (cfg_ok_s) begin
                pattern_r <= bus.cfg_pattern;
                len_r     <= bus.cfg_len;
                overlap_r <= bus.cfg_overlap;
            end else begin
                pattern_r <= pattern_r;
                len_r     <= len_r;
                overlap_r <= overlap_r;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_s),
        .clr   (bus.cnt_clr),
        .q     (bus.match_cnt)
    );

    assign bus.z       = z_r;
    assign bus.cfg_err = cfg_err_r;

endmodule

// File: tb/tb_param_seq_detect.sv
// Directed self-checking bench: two detectors (8-bit and 2-bit counters) share one stimulus stream.
module tb_param_seq_detect;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    param_seq_detect_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) a ();
    param_seq_detect_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) b ();

    param_seq_detect #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .DEF_PATTERN(8'b0000_1001), .DEF_LEN(4))
        dut (.clk(clk), .reset(reset), .bus(a));
    param_seq_detect #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2), .DEF_PATTERN(8'b0000_1001), .DEF_LEN(4))
        dut2 (.clk(clk), .reset(reset), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic e, input logic bit_x, input logic ld, input logic [7:0] pat,
                           input logic [3:0] len, input logic ovl, input logic clr);
        a.en = e; a.x = bit_x; a.cfg_load = ld; a.cfg_pattern = pat; a.cfg_len = len;
        a.cfg_overlap = ovl; a.cnt_clr = clr;
        b.en = e; b.x = bit_x; b.cfg_load = ld; b.cfg_pattern = pat; b.cfg_len = len;
        b.cfg_overlap = ovl; b.cnt_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic bit_x, input logic clr);
        set_all(1'b1, bit_x, 1'b0, 8'h00, 4'd0, 1'b0, clr);
        tick();
    endtask

    task automatic idle();
        set_all(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        set_all(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
        tick();
        set_all(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic clear_cnt();
        set_all(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        tick();
        set_all(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        check("cnt_clr", 32'(a.match_cnt), 32'd0);
    endtask

    initial begin
        logic [6:0]  stream7;
        logic [6:0]  expz;
        logic [15:0] stream16;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        set_all(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        check("reset_z", 32'(a.z), 32'd0);
        check("reset_cnt", 32'(a.match_cnt), 32'd0);
        check("reset_cfg_err", 32'(a.cfg_err), 32'd0);

        // 1: default 1001, overlap on
        stream7 = 7'b1001001;
        expz    = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            send(stream7[i], 1'b0);
            check($sformatf("t1_z_bit%0d", 7 - i), 32'(a.z), 32'(expz[i]));
        end
        check("t1_cnt", 32'(a.match_cnt), 32'd2);

        // 2: same stream, overlap off
        load(8'b0000_1001, 4'd4, 1'b0);
        check("t2_load_z", 32'(a.z), 32'd0);
        check("t2_load_err", 32'(a.cfg_err), 32'd0);
        clear_cnt();
        expz = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            send(stream7[i], 1'b0);
            check($sformatf("t2_z_bit%0d", 7 - i), 32'(a.z), 32'(expz[i]));
        end
        check("t2_cnt", 32'(a.match_cnt), 32'd1);

        // 3: len 3 pattern 111, five ones
        load(8'b0000_0111, 4'd3, 1'b1);
        clear_cnt();
        expz = 7'b0000111;
        for (int i = 4; i >= 0; i--) begin
            send(1'b1, 1'b0);
            check($sformatf("t3_z_bit%0d", 5 - i), 32'(a.z), 32'(expz[i]));
        end
        check("t3_cnt", 32'(a.match_cnt), 32'd3);

        // 4: illegal lengths rejected, default kept
        load(8'b0000_1001, 4'd4, 1'b1);
        load(8'hFF, 4'd0, 1'b1);
        check("t4_err_len0", 32'(a.cfg_err), 32'd1);
        idle();
        check("t4_err_pulse0", 32'(a.cfg_err), 32'd0);
        load(8'hFF, 4'd9, 1'b0);
        check("t4_err_len9", 32'(a.cfg_err), 32'd1);
        idle();
        check("t4_err_pulse9", 32'(a.cfg_err), 32'd0);
        clear_cnt();
        stream7 = 7'b0001001;
        expz    = 7'b0000001;
        for (int i = 3; i >= 0; i--) begin
            send(stream7[i], 1'b0);
            check($sformatf("t4_z_bit%0d", 4 - i), 32'(a.z), 32'(expz[i]));
        end
        check("t4_cnt", 32'(a.match_cnt), 32'd1);

        // 5: en gaps between bits
        load(8'b0000_1001, 4'd4, 1'b1);
        clear_cnt();
        for (int i = 3; i >= 0; i--) begin
            send(stream7[i], 1'b0);
            check($sformatf("t5_z_bit%0d", 4 - i), 32'(a.z), 32'(expz[i]));
            idle();
            check($sformatf("t5_z_gap%0d", 4 - i), 32'(a.z), 32'd0);
            idle();
        end
        check("t5_cnt", 32'(a.match_cnt), 32'd1);

        // 6: five matches, 2-bit counter saturates
        clear_cnt();
        check("t6_cnt2_clr", 32'(b.match_cnt), 32'd0);
        stream16 = 16'b1001_0010_0100_1001;
        for (int i = 15; i >= 0; i--) begin
            send(stream16[i], 1'b0);
        end
        check("t6_z_last", 32'(b.z), 32'd1);
        check("t6_cnt8", 32'(a.match_cnt), 32'd5);
        check("t6_cnt2_sat", 32'(b.match_cnt), 32'd3);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        check("t6_clr_match_z", 32'(a.z), 32'd1);
        check("t6_clr_match_cnt8", 32'(a.match_cnt), 32'd1);
        check("t6_clr_match_cnt2", 32'(b.match_cnt), 32'd1);

        // 6b: async reset after three bits of 1001
        idle();
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        set_all(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_z", 32'(a.z), 32'd0);
        check("t6_rst_cnt", 32'(a.match_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send(1'b1, 1'b0);
        check("t6_rst_no_match", 32'(a.z), 32'd0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("t6_rst_refill_match", 32'(a.z), 32'd1);
        check("t6_rst_refill_cnt", 32'(a.match_cnt), 32'd1);
        idle();
        check("t6_rst_pulse_end", 32'(a.z), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
